// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative 32-bit multiply/divide producing the HI/LO pair for
// mult, multu, div and divu. One iteration per cycle on unsigned magnitudes,
// with the result signs applied in a final fix-up cycle.
module muldiv_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t      state;
  logic [4:0]  cnt;
  logic        is_div;
  logic        neg_res;
  logic        neg_rem;

  // Working registers: upper/lower hold product halves or remainder/quotient,
  // m holds the multiplicand or divisor magnitude.
  logic [31:0] upper;
  logic [31:0] lower;
  logic [31:0] m;

  logic signed [31:0] a_s;
  logic signed [31:0] b_s;
  logic               sgn_op;
  logic [31:0]        a_mag;
  logic [31:0]        b_mag;

  logic [32:0] mul_sum;
  logic [32:0] rem_sh;
  logic        sub_ok;
  logic [31:0] nxt_upper;
  logic [31:0] nxt_lower;

  logic [31:0] res_hi;
  logic [31:0] res_lo;

  function automatic logic [31:0] neg32(input logic [31:0] v);
    return ~v + 32'd1;
  endfunction

  function automatic logic [63:0] neg64(input logic [63:0] v);
    return ~v + 64'd1;
  endfunction

  // Operand magnitudes for the accept edge; unsigned ops pass straight through.
  always_comb begin
    a_s    = a;
    b_s    = b;
    sgn_op = ~op[0];
    a_mag  = (sgn_op && (a_s < 0)) ? neg32(a) : a;
    b_mag  = (sgn_op && (b_s < 0)) ? neg32(b) : b;
  end

  // One shift-add or restoring-divide step on the working registers.
  always_comb begin
    mul_sum   = {1'b0, upper} + {1'b0, (lower[0] ? m : 32'd0)};
    rem_sh    = {upper, lower[31]};
    sub_ok    = (rem_sh >= {1'b0, m});
    nxt_upper = 32'd0;
    nxt_lower = 32'd0;
    if (is_div) begin
      // The remainder after this step is below m, so 32 bits always hold it.
      nxt_upper = sub_ok ? (rem_sh[31:0] - m) : rem_sh[31:0];
      nxt_lower = {lower[30:0], sub_ok};
    end else begin
      nxt_upper = mul_sum[32:1];
      nxt_lower = {mul_sum[0], lower[31:1]};
    end
  end

  // Sign fix-up of the finished magnitude result.
  always_comb begin
    res_hi = 32'd0;
    res_lo = 32'd0;
    if (is_div) begin
      res_lo = neg_res ? neg32(lower) : lower;
      res_hi = neg_rem ? neg32(upper) : upper;
    end else begin
      {res_hi, res_lo} = neg_res ? neg64({upper, lower}) : {upper, lower};
    end
  end

  // Control FSM plus the architectural HI/LO registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= 5'd0;
      busy    <= 1'b0;
      done    <= 1'b0;
      is_div  <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      hi      <= 32'd0;
      lo      <= 32'd0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state   <= RUN;
            busy    <= 1'b1;
            cnt     <= 5'd31;
            is_div  <= op[1];
            // A zero divisor keeps the all-ones quotient unsigned; the
            // remainder path already reproduces the dividend.
            neg_res <= sgn_op && (a[31] ^ b[31]) && !(op[1] && (b == 32'd0));
            neg_rem <= sgn_op && op[1] && a[31];
          end else begin
            if (mthi) hi <= wdata;
            if (mtlo) lo <= wdata;
          end
        end
        RUN: begin
          if (cnt == 5'd0) begin
            state <= FIX;
          end else begin
            cnt <= cnt - 5'd1;
          end
        end
        FIX: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
          hi    <= res_hi;
          lo    <= res_lo;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Datapath working registers: loaded on accept, stepped every RUN cycle.
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      upper <= 32'd0;
      lower <= op[1] ? a_mag : b_mag;
      m     <= op[1] ? b_mag : a_mag;
    end else if (state == RUN) begin
      upper <= nxt_upper;
      lower <= nxt_lower;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed-vector bench for muldiv_unit.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        mthi;
  logic        mtlo;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int bcnt     = 0;
  int dcnt     = 0;

  muldiv_unit dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .mthi  (mthi),
    .mtlo  (mtlo),
    .wdata (wdata),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge, counting busy cycles on the way.
  task automatic step();
    if (busy) bcnt++;
    @(negedge clk);
    cyc++;
  endtask

  // Present start for exactly one rising edge; caller sits on a falling edge.
  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    op    = o;
    a     = x;
    b     = y;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc   = 0;
    bcnt  = 0;
  endtask

  task automatic wait_done();
    while (!done && cyc < 100) step();
  endtask

  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] ehi, input logic [31:0] elo);
    issue(o, x, y);
    wait_done();
    check_eq({tag, "_lat"}, 64'(cyc), 64'd33);
    check_eq({tag, "_hi"}, 64'(hi), 64'(ehi));
    check_eq({tag, "_lo"}, 64'(lo), 64'(elo));
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    op    = 2'b00;
    a     = 32'd0;
    b     = 32'd0;
    mthi  = 1'b0;
    mtlo  = 1'b0;
    wdata = 32'd0;
    repeat (2) @(negedge clk);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_done", 64'(done), 64'd0);
    check_eq("rst_hi", 64'(hi), 64'd0);
    check_eq("rst_lo", 64'(lo), 64'd0);
    reset = 1'b1;
    @(negedge clk);

    // multu with all-ones operands, plus busy width and done pulse shape
    run_op("multu_max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    check_eq("multu_busy_cycles", 64'(bcnt), 64'd33);
    check_eq("multu_done", 64'(done), 64'd1);
    check_eq("multu_busy_done", 64'(busy), 64'd0);
    step();
    check_eq("multu_done_clear", 64'(done), 64'd0);

    // signed multiply, then divu started in the done cycle
    run_op("mult_neg", 2'b00, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1);
    issue(2'b11, 32'd100, 32'd7);
    check_eq("b2b_done_low", 64'(done), 64'd0);
    check_eq("b2b_busy", 64'(busy), 64'd1);
    wait_done();
    check_eq("b2b_lat", 64'(cyc), 64'd33);
    check_eq("b2b_hi", 64'(hi), 64'd2);
    check_eq("b2b_lo", 64'(lo), 64'd14);

    // signed divide: negative dividend and the overflow case
    run_op("div_neg", 2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("div_ovf", 2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);

    // divide by zero
    run_op("div_z", 2'b10, 32'h12345678, 32'd0, 32'h12345678, 32'hFFFFFFFF);
    run_op("divu_z", 2'b11, 32'h12345678, 32'd0, 32'h12345678, 32'hFFFFFFFF);
    run_op("div_z_neg", 2'b10, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 32'hFFFFFFFF);

    // start and mthi while busy are ignored; hi/lo hold mid-operation
    issue(2'b01, 32'h00010000, 32'h00010000);
    repeat (9) step();
    op    = 2'b11;
    a     = 32'd100;
    b     = 32'd7;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (10) step();
    mthi  = 1'b1;
    wdata = 32'hAAAA5555;
    step();
    mthi  = 1'b0;
    check_eq("busy_mthi_hi", 64'(hi), 64'hFFFFFFF9);
    check_eq("busy_hold_lo", 64'(lo), 64'hFFFFFFFF);
    wait_done();
    check_eq("ign_lat", 64'(cyc), 64'd33);
    check_eq("ign_hi", 64'(hi), 64'd1);
    check_eq("ign_lo", 64'(lo), 64'd0);
    step();

    // mtlo in idle
    mtlo  = 1'b1;
    wdata = 32'h0000BEEF;
    step();
    mtlo  = 1'b0;
    check_eq("mtlo_lo", 64'(lo), 64'h0000BEEF);
    check_eq("mtlo_hi", 64'(hi), 64'd1);

    // start wins over a simultaneous mthi
    mthi  = 1'b1;
    wdata = 32'h13572468;
    issue(2'b01, 32'd3, 32'd9);
    mthi  = 1'b0;
    check_eq("start_wins_hi", 64'(hi), 64'd1);
    wait_done();
    check_eq("sw_hi", 64'(hi), 64'd0);
    check_eq("sw_lo", 64'(lo), 64'd27);
    step();

    // mthi and mtlo together write both
    mthi  = 1'b1;
    mtlo  = 1'b1;
    wdata = 32'hCAFEF00D;
    step();
    mthi  = 1'b0;
    mtlo  = 1'b0;
    check_eq("both_hi", 64'(hi), 64'hCAFEF00D);
    check_eq("both_lo", 64'(lo), 64'hCAFEF00D);

    // asynchronous reset mid-operation abandons it
    issue(2'b00, 32'd5, 32'd6);
    repeat (14) step();
    reset = 1'b0;
    #1;
    check_eq("arst_busy", 64'(busy), 64'd0);
    check_eq("arst_hi", 64'(hi), 64'd0);
    check_eq("arst_lo", 64'(lo), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    dcnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    check_eq("arst_no_done", 64'(dcnt), 64'd0);
    run_op("post_rst", 2'b01, 32'd6, 32'd7, 32'd0, 32'd42);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit that produces the HI/LO result pair for MIPS `mult`, `multu`, `div` and `divu`. It is the sequential counterpart to the single-cycle ALU: the datapath hands over two register-file operands with a start pulse, and the unit returns a 64-bit product or a quotient/remainder after a fixed latency. The datapath reads the HI and LO registers for `mfhi`/`mflo` and writes them directly for `mthi`/`mtlo`.

## Interface

- No parameters. Operand width is fixed at 32.
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  accept a new operation; sampled only when busy=0.
- op  in  2  operation select: 00 mult (signed), 01 multu, 10 div (signed), 11 divu.
- a  in  32  multiplicand or dividend (rs).
- b  in  32  multiplier or divisor (rt).
- mthi  in  1  write `wdata` into HI; honoured only when idle and start=0.
- mtlo  in  1  write `wdata` into LO; same conditions as mthi.
- wdata  in  32  data for mthi/mtlo.
- busy  out  1  high from the accepting edge until the edge that asserts done.
- done  out  1  one-cycle pulse; HI/LO are valid from that edge onward.
- hi  out  32  HI register: upper product or remainder.
- lo  out  32  LO register: lower product or quotient.

## Operation

- States: IDLE, RUN, FIX.
- IDLE → RUN on a rising edge with start=1. At that edge the unit:
  - latches op;
  - latches |a| and |b| for signed ops, or a and b for unsigned ops;
  - latches the result-sign flags;
  - loads the iteration counter with 31.
- RUN performs one iteration per cycle. The counter decrements and wraps only through the exit, with no modular reuse. RUN → FIX on the edge where counter=0 finishes its iteration, so there are exactly 32 iterations.
- Multiply uses a 64-bit shift-add on unsigned magnitudes. For a signed op with sign(a)≠sign(b), FIX negates the 64-bit product (two's complement).
- Divide uses restoring division on unsigned magnitudes, one quotient bit per iteration. The partial remainder is 33 bits so the subtract borrow is not lost. FIX applies signs:
  - quotient is negated when sign(a)≠sign(b);
  - remainder takes the sign of a.
- Divide by zero (b=0) has the same latency and produces HI=a (the original, unmodified dividend) and LO=32'hFFFFFFFF, for both div and divu.
- Signed overflow case: div 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0. This falls out of the magnitude method; no special case is needed.
- FIX → IDLE on the next edge. That edge writes HI/LO and sets done=1 for one cycle.
- start while busy=1 is ignored; there is no queueing.
- mthi/mtlo while busy=1 are ignored.
- If start and mthi/mtlo are asserted together in IDLE, start wins and the write is dropped. If mthi and mtlo are asserted together, both registers take wdata.
- HI/LO hold their value across operations until a done edge or an mthi/mtlo write. Internal working registers never appear on hi/lo mid-operation.

## Timing

- Reset (asynchronous, low): state=IDLE, busy=0, done=0, hi=0, lo=0, counter=0. This takes effect immediately, including mid-operation. The operation in flight is abandoned and produces no done pulse.
- Accept edge E0 (start=1, busy=0): busy=1 after E0.
- Iterations run on edges E1..E32. FIX is the cycle after E32.
- E33 writes HI/LO and drives done=1, busy=0 during the cycle E33→E34. done returns to 0 after E34 unless a new completion occurs.
- Back-to-back: start may be high in the done cycle, since busy=0 then. It is accepted at E34, giving a throughput of one operation per 34 cycles.
- mthi/mtlo take effect at the edge they are sampled, and are visible on hi/lo after that edge.
- Outputs are registered; there is no combinational path from inputs to busy, done, hi or lo.

## Test plan

- multu a=0xFFFFFFFF, b=0xFFFFFFFF → busy high for 33 cycles, done pulse at E33, hi=0xFFFFFFFE, lo=0x00000001.
- mult a=0xFFFFFFFD (−3), b=5 → hi=0xFFFFFFFF, lo=0xFFFFFFF1. Then back-to-back divu a=100, b=7 started in the done cycle → lo=0x0000000E, hi=0x00000002.
- div a=0xFFFFFFF9 (−7), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. Also div a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0.
- div and divu with a=0x12345678, b=0 → hi=0x12345678, lo=0xFFFFFFFF, with latency unchanged at 33 cycles to done.
- Operation control:
  - Pulse start with new operands at E10 of a running op → ignored; the result matches the first op.
  - Assert mthi with wdata=0xAAAA5555 mid-op → ignored.
  - Assert mtlo with wdata=0x0000BEEF in idle → lo=0x0000BEEF next edge, hi unchanged.
- Start mult, assert reset low at E15 for 2 cycles → busy=0, hi=lo=0 immediately, no done pulse. A fresh multu 6×7 afterwards → lo=42, hi=0.
